// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: bit-FSM states, byte-0 field indices and
// mouse_atari bit positions (also used by the ikbd).
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } bit_state_t;

  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

  localparam int MA_XB = 0;
  localparam int MA_XA = 1;
  localparam int MA_YA = 2;
  localparam int MA_YB = 3;
  localparam int MA_LB = 4;
  localparam int MA_RB = 5;

  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One mouse axis: saturating signed motion accumulator drained one count per
// step tick into a registered quadrature phase pair.
module quad_axis #(
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              res,
  input  logic              tick,
  input  logic              add_en,
  input  logic signed [9:0] delta,
  output logic              pha,
  output logic              phb
);

  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [SW-1:0]    a_v, d_v, s_v, sum;
  logic                    step;

  // Packet delta and step decrement combine before a single saturation.
  always_comb begin
    step = tick && (acc != '0);
    a_v  = SW'(acc);
    d_v  = '0;
    if (add_en) d_v = SW'(delta);
    s_v  = '0;
    if (step) s_v = acc[ACC_W-1] ? '1 : SW'(1);
    sum  = a_v + d_v - s_v;
    if (sum > MAXV)      acc_nx = ACC_W'(MAXV);
    else if (sum < MINV) acc_nx = ACC_W'(MINV);
    else                 acc_nx = ACC_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      acc <= '0;
      pha <= 1'b0;
      phb <= 1'b0;
    end else begin
      acc <= acc_nx;
      if (step) begin
        if (!acc[ACC_W-1]) {pha, phb} <= {~phb, pha};
        else               {pha, phb} <= {phb, ~pha};
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_quad.sv
// PS/2 stream-mode mouse receiver driving Atari ST quadrature and buttons.
// Optional idle watchdog enabled by defining PS2_MOUSE_TIMEOUT_EN.
module ps2_mouse_quad
  import ps2_pkg::*;
#(
  parameter int STEP_DIV = 200,
  parameter int ACC_W    = 12,
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 4000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       mouse_clk,
  input  logic       mouse_data,
  output logic [5:0] mouse_atari,
  output logic       pkt_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int PW = $clog2(STEP_DIV);

  logic          mclk_s1, mclk_s2, mdat_s1, mdat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, fall, dbit;

  always_ff @(posedge clk) begin
    if (res) begin
      mclk_s1  <= 1'b1;
      mclk_s2  <= 1'b1;
      mdat_s1  <= 1'b1;
      mdat_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      dbit     <= 1'b1;
    end else begin
      mclk_s1 <= mouse_clk;
      mclk_s2 <= mclk_s1;
      mdat_s1 <= mouse_data;
      mdat_s2 <= mdat_s1;
      fall    <= 1'b0;
      if (mclk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= mclk_s2;
        filt_cnt <= '0;
        fall     <= ~mclk_s2;
        dbit     <= mdat_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  bit_state_t  state, state_nx;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [1:0]  byte_idx;
  logic        hdr_l, hdr_r, hdr_xs, hdr_ys, hdr_xo, hdr_yo;
  logic [7:0]  bx;
  logic        btn_l, btn_r;
  logic        bit_err, byte_done, hdr_err, to_fire, add_fire;

`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          filt_prev;

  always_ff @(posedge clk) begin
    if (res) begin
      idle_cnt  <= '0;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (filt_prev != filt_clk || to_fire) idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT))   idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign to_fire = (idle_cnt == TW'(TIMEOUT - 1)) && (filt_prev == filt_clk) &&
                   (state != ST_IDLE || byte_idx != 2'd0);
`else
  assign to_fire = 1'b0;
  // TIMEOUT stays in the parameter list so both builds share one interface.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (res) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    bit_err   = 1'b0;
    byte_done = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dbit) state_nx = ST_DATA;
          else       bit_err  = 1'b1;
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          if (odd_ok(shreg, dbit)) begin
            state_nx = ST_STOP;
          end else begin
            state_nx = ST_IDLE;
            bit_err  = 1'b1;
          end
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (dbit) byte_done = 1'b1;
          else      bit_err   = 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (to_fire) begin
      state_nx = ST_IDLE;
    end
    hdr_err  = byte_done && (byte_idx == 2'd0) && !shreg[B0_SYNC];
    add_fire = byte_done && (byte_idx == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      {hdr_l, hdr_r, hdr_xs, hdr_ys, hdr_xo, hdr_yo} <= '0;
      bx        <= '0;
      btn_l     <= 1'b0;
      btn_r     <= 1'b0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pkt_valid <= add_fire;
      frame_err <= bit_err | hdr_err | to_fire;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == ST_DATA) begin
        shreg   <= {dbit, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (bit_err || to_fire) begin
        byte_idx <= '0;
      end else if (byte_done) begin
        case (byte_idx)
          2'd0: begin
            if (shreg[B0_SYNC]) begin
              {hdr_l, hdr_r}   <= {shreg[B0_L], shreg[B0_R]};
              {hdr_xs, hdr_ys} <= {shreg[B0_XS], shreg[B0_YS]};
              {hdr_xo, hdr_yo} <= {shreg[B0_XO], shreg[B0_YO]};
              byte_idx         <= 2'd1;
            end
          end
          2'd1: begin
            bx       <= shreg;
            byte_idx <= 2'd2;
          end
          default: begin
            btn_l    <= hdr_l;
            btn_r    <= hdr_r;
            byte_idx <= 2'd0;
          end
        endcase
      end
    end
  end

  // Byte 2 is consumed straight from the shift register; Y is negated because
  // Atari Y grows downward.
  logic signed [9:0] dx, dy;
  always_comb begin
    dx = '0;
    dy = '0;
    if (!hdr_xo) dx = {hdr_xs, hdr_xs, bx};
    if (!hdr_yo) dy = -{hdr_ys, hdr_ys, shreg};
  end

  logic [PW-1:0] presc;
  logic          tick;
  assign tick = (presc == PW'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (res || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  logic xa, xb, ya, yb;

  quad_axis #(.ACC_W(ACC_W)) u_x (
    .clk   (clk),
    .res   (res),
    .tick  (tick),
    .add_en(add_fire),
    .delta (dx),
    .pha   (xa),
    .phb   (xb)
  );

  quad_axis #(.ACC_W(ACC_W)) u_y (
    .clk   (clk),
    .res   (res),
    .tick  (tick),
    .add_en(add_fire),
    .delta (dy),
    .pha   (ya),
    .phb   (yb)
  );

  always_comb begin
    mouse_atari        = '0;
    mouse_atari[MA_XB] = xb;
    mouse_atari[MA_XA] = xa;
    mouse_atari[MA_YA] = ya;
    mouse_atari[MA_YB] = yb;
    mouse_atari[MA_LB] = btn_l;
    mouse_atari[MA_RB] = btn_r;
  end

endmodule

// File: tb/tb_ps2_mouse_quad.sv
// Directed bench for ps2_mouse_quad: PS/2 frames in, quadrature/buttons out.
module tb_ps2_mouse_quad;

  localparam int H = 15;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       mouse_clk = 1'b1;
  logic       mouse_data = 1'b1;
  logic [5:0] mouse_atari;
  logic       pkt_valid, frame_err;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  ps2_mouse_quad dut (
    .clk        (clk),
    .res        (res),
    .mouse_clk  (mouse_clk),
    .mouse_data (mouse_data),
    .mouse_atari(mouse_atari),
    .pkt_valid  (pkt_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned pkt_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned pkt_cyc = 0;
  logic [1:0]  xprev = 2'b00;
  logic [1:0]  yprev = 2'b00;
  logic [1:0]  xq[$];
  logic [1:0]  yq[$];
  int unsigned xcyc[$];
  int          acc_max = 0;
  int          acc_min = 0;

  // Phase pairs are recorded as {A,B}.
  always @(negedge clk) begin
    logic [1:0] xp, yp;
    int a;
    cyc++;
    if (pkt_valid) begin
      pkt_cnt++;
      pkt_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    xp = {mouse_atari[1], mouse_atari[0]};
    yp = {mouse_atari[2], mouse_atari[3]};
    if (xp != xprev) begin
      xq.push_back(xp);
      xcyc.push_back(cyc);
    end
    if (yp != yprev) yq.push_back(yp);
    xprev = xp;
    yprev = yp;
    a = int'($signed(dut.u_x.acc));
    if (a > acc_max) acc_max = a;
    if (a < acc_min) acc_min = a;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    mouse_clk  = 1'b1;
    mouse_data = 1'b1;
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    pkt_cnt = 0;
    err_cnt = 0;
    xq.delete();
    yq.delete();
    xcyc.delete();
    xprev   = 2'b00;
    yprev   = 2'b00;
    acc_max = 0;
    acc_min = 0;
  endtask

  task automatic ps2_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      mouse_data = frame[i];
      repeat (H) @(posedge clk);
      mouse_clk = 1'b0;
      repeat (H) @(posedge clk);
      mouse_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    ps2_bits(f, 11);
    mouse_data = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic wait_pkts(input int unsigned n, input int budget);
    int k = 0;
    while (pkt_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  function automatic int qx(input int i);
    return (i < xq.size()) ? int'(xq[i]) : -1;
  endfunction

  function automatic int qy(input int i);
    return (i < yq.size()) ? int'(yq[i]) : -1;
  endfunction

  initial begin
    int lat;
    int n0;
    logic [10:0] part;

    // Reset and long idle
    do_reset();
    check("rst_atari", int'(mouse_atari), 0);
    check("rst_pkt", int'(pkt_valid), 0);
    check("rst_err", int'(frame_err), 0);
    repeat (10000) @(posedge clk);
    check("idle_atari", int'(mouse_atari), 0);
    check("idle_pkt", pkt_cnt, 0);
    check("idle_err", err_cnt, 0);

    // dX=+3, left button
    do_reset();
    send_pkt(8'h09, 8'h03, 8'h00);
    wait_pkts(1, 2000);
    repeat (4 * 200 + 20) @(posedge clk);
    check("p1_pkt", pkt_cnt, 1);
    check("p1_err", err_cnt, 0);
    check("p1_left", int'(mouse_atari[4]), 1);
    check("p1_right", int'(mouse_atari[5]), 0);
    check("p1_xsteps", xq.size(), 3);
    check("p1_x0", qx(0), 2);
    check("p1_x1", qx(1), 3);
    check("p1_x2", qx(2), 1);
    check("p1_ysteps", yq.size(), 0);
    lat = (xcyc.size() > 0) ? int'(xcyc[0] - pkt_cyc) : 9999;
    check("p1_latency_ok", int'(lat >= 1 && lat <= 201), 1);

    // dY=-2 -> two positive Y steps
    do_reset();
    send_pkt(8'h28, 8'h00, 8'hFE);
    wait_pkts(1, 2000);
    repeat (3 * 200 + 20) @(posedge clk);
    check("p2_pkt", pkt_cnt, 1);
    check("p2_buttons", int'(mouse_atari[5:4]), 0);
    check("p2_ysteps", yq.size(), 2);
    check("p2_y0", qy(0), 2);
    check("p2_y1", qy(1), 3);
    check("p2_xsteps", xq.size(), 0);

    // Bad parity: parity error, then the stop bit arrives in IDLE as a bad start
    do_reset();
    send_byte(8'h55, 1'b1);
    check("p3_bad_parity_err", err_cnt, 2);
    send_pkt(8'h08, 8'h01, 8'h01);
    wait_pkts(1, 2000);
    repeat (2 * 200 + 20) @(posedge clk);
    check("p3_pkt", pkt_cnt, 1);
    check("p3_err", err_cnt, 2);
    check("p3_xsteps", xq.size(), 1);
    check("p3_x0", qx(0), 2);
    check("p3_ysteps", yq.size(), 1);
    check("p3_y0", qy(0), 1);

    // Stray non-header byte
    do_reset();
    send_byte(8'h00, 1'b0);
    check("p4_stray_err", err_cnt, 1);
    send_pkt(8'h0A, 8'h00, 8'h00);
    wait_pkts(1, 2000);
    repeat (50) @(posedge clk);
    check("p4_pkt", pkt_cnt, 1);
    check("p4_err", err_cnt, 1);
    check("p4_right", int'(mouse_atari[5]), 1);
    check("p4_left", int'(mouse_atari[4]), 0);
    check("p4_xsteps", xq.size(), 0);

    // Reset mid-frame discards the partial byte
    do_reset();
    part = {1'b1, 1'b0, 8'h08, 1'b0};
    ps2_bits(part, 4);
    do_reset();
    send_pkt(8'h08, 8'h01, 8'h00);
    wait_pkts(1, 2000);
    repeat (200 + 20) @(posedge clk);
    check("p5_pkt", pkt_cnt, 1);
    check("p5_err", err_cnt, 0);
    check("p5_x0", qx(0), 2);

    // Saturation burst
    do_reset();
    for (int i = 0; i < 40; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    wait_pkts(40, 2000);
    check("sat_pkt", pkt_cnt, 40);
    check("sat_acc_max", acc_max, 2047);
    check("sat_acc_min", acc_min, 0);
    check("sat_stepping", int'(xq.size() >= 100), 1);
    n0 = xq.size();
    repeat (1000) @(posedge clk);
    check("sat_steps_1000cyc", xq.size() - n0, 5);

`ifdef PS2_MOUSE_TIMEOUT_EN
    // Watchdog drops a partial byte after TIMEOUT idle cycles
    do_reset();
    ps2_bits(part, 4);
    mouse_data = 1'b1;
    repeat (4100) @(posedge clk);
    check("to_err", err_cnt, 1);
    send_pkt(8'h08, 8'h01, 8'h00);
    wait_pkts(1, 2000);
    check("to_pkt", pkt_cnt, 1);
    check("to_err_after", err_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_quad.md
Name: ps2_mouse_quad

Overview:
- Receives PS/2 mouse stream packets and converts them into the Atari ST mouse signals.
- Outputs are quadrature phases XA/XB/YA/YB plus left and right buttons.
- Sits directly upstream of the ikbd, which consumes mouse_atari[5:0] on joystick port 0.
- Device-to-host only; the mouse is expected to already be in stream mode.

Parameters:
- STEP_DIV, 200: clk cycles between quadrature step opportunities (10 kHz at 2 MHz).
- ACC_W, 12: width of the signed per-axis pending-motion accumulators.
- FILT_LEN, 8: cycles the synchronized PS/2 clock must be stable before an edge is accepted.
- TIMEOUT, 4000: idle cycles after which a partial byte or packet is discarded (used only with the optional feature).

Ports:
- clk  in  1  system clock (2 MHz).
- res  in  1  synchronous, active-high reset.
- mouse_clk  in  1  PS/2 mouse clock, asynchronous.
- mouse_data  in  1  PS/2 mouse data, asynchronous.
- mouse_atari  out  6  [0]=XB, [1]=XA, [2]=YA, [3]=YB, [4]=left button, [5]=right button; all active-high.
- pkt_valid  out  1  one-cycle pulse when a 3-byte packet is accepted.
- frame_err  out  1  one-cycle pulse on start, parity or stop error, or on a header resync.

Behaviour:
- Reset (res=1 at a clk edge):
  - mouse_atari=0, pkt_valid=0, frame_err=0.
  - Accumulators=0, quadrature phases=0, byte and bit counters=0, prescaler=0.
  - res mid-frame discards the partial byte and packet.
- Input conditioning:
  - Both PS/2 lines pass through 2-FF synchronizers.
  - The clock is filtered: the filtered level changes only after FILT_LEN consecutive equal samples.
  - Data is sampled on each filtered falling edge.
- Bit FSM, states IDLE -> DATA -> PARITY -> STOP:
  - IDLE: a falling edge with data=0 goes to DATA; data=1 pulses frame_err and stays in IDLE.
  - DATA: 8 bits, LSB first.
  - PARITY: checks odd parity over data plus parity bit.
  - STOP: data must be 1.
  - Any error pulses frame_err, drops the byte, resets the byte index to 0 and returns to IDLE.
- Packet assembly:
  - Byte 0 must have bit3=1; otherwise pulse frame_err, drop the byte and stay at index 0.
  - Byte 0 fields: bit0=L, bit1=R, bit4=X sign, bit5=Y sign, bit6=X overflow, bit7=Y overflow.
  - Byte 1 is X and byte 2 is Y; each is 9-bit two's complement with its sign bit from byte 0.
  - On the cycle after the stop bit of byte 2:
    - pulse pkt_valid;
    - load mouse_atari[4]=L and mouse_atari[5]=R;
    - add dX into acc_x and -dY into acc_y (Atari Y grows downward);
    - an axis with its overflow bit set contributes 0.
  - Accumulator adds saturate at ±(2^(ACC_W-1)-1), never wrap.
- Step engine:
  - The prescaler counts 0..STEP_DIV-1; a tick occurs at wrap.
  - Per tick, each axis with acc != 0 advances its phase one state and moves acc one toward 0.
  - Phase sequence (A,B): positive direction 00->10->11->01->00; negative is the reverse.
  - X and Y step independently on the same tick.
  - Phase state drives mouse_atari[1:0] and [3:2] directly from registers; no combinational path from inputs.
- Simultaneous events:
  - A packet add and a step decrement in the same cycle combine as acc + delta − step_dir, then saturate.
- Latency: the first X phase change occurs at the first tick after pkt_valid, within at most STEP_DIV+1 cycles.

Optional Feature:
- Macro: PS2_MOUSE_TIMEOUT_EN.
- Defined:
  - An idle counter is reset on every accepted filtered edge.
  - Reaching TIMEOUT while the bit FSM is not in IDLE, or the byte index is nonzero, clears both to idle/0 and pulses frame_err.
  - This resynchronizes after hot-plug or a lost edge.
- Undefined: no watchdog; recovery relies only on the byte-0 bit3 check. TIMEOUT is unused.

Decomposition:
- Shared package ps2_pkg holds:
  - bit FSM state enum;
  - byte-0 field bit-index constants;
  - mouse_atari bit-index constants (MA_XB, MA_XA, MA_YA, MA_YB, MA_LB, MA_RB).
- The ikbd uses the same constants.
- One sub-module: quad_axis. It holds the accumulator, saturation and phase stepping, and is instantiated twice (X, Y).

Test Plan:
- Reset then idle lines high for 10000 cycles -> mouse_atari=6'b0, no pkt_valid, no frame_err.
- Packet 0x09,0x03,0x00 -> pkt_valid once; left button=1; X phases 00->10->11->01 over 3 ticks, then static; Y unchanged.
- Packet 0x28,0x00,0xFE (dY=−2) -> acc_y=+2; Y steps twice in the positive direction; mouse_atari[4:5]=0.
- Byte with bad parity, then valid packet 0x08,0x01,0x01 -> frame_err pulse; packet accepted; X +1 step, Y −1 step.
- Stray byte 0x00 before header 0x0A,0x00,0x00 -> frame_err on the stray byte; packet accepted with right button=1.
- 40 packets of dX=+127 at STEP_DIV=200 -> acc_x saturates at 2047; phases keep stepping; no wrap to negative.
- With PS2_MOUSE_TIMEOUT_EN: send 4 bits, then idle for TIMEOUT cycles -> frame_err pulse; the following valid packet is accepted.
